// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a req/ready/rvalid handshake.
// One access at a time, with a fixed access latency. The result comes back as a single-cycle
// response pulse. A stall is raised toward the hazard unit while an access is in flight.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset; clears memory and aborts any access
//   req_i     request valid
//   we_i      1 = write, 0 = read (qualified by req_i)
//   addr_i    byte address, word index addr_i[31:2]
//   wdata_i   write data
//   ready_o   responder idle and able to accept this cycle
//   rvalid_o  one-cycle response pulse per accepted request
//   rdata_o   read data while rvalid_o=1, held otherwise
//   err_o     with rvalid_o: request was misaligned or out of range
//   stall_o   combinational pipeline stall request
module dmem_responder #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DepthW   = 30'(DEPTH);
  localparam logic [3:0]  WaitInit = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              legal_q, legal_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [DEPTH];

  logic              in_legal;
  logic [IdxW-1:0]   in_idx;
  logic              accept;
  logic              commit;
  logic              c_we;
  logic              c_legal;
  logic [IdxW-1:0]   c_idx;
  logic [31:0]       c_wdata;

  assign in_legal = (addr_i[1:0] == 2'b00) && (addr_i[31:2] < DepthW);
  assign in_idx   = addr_i[IdxW+1:2];
  assign accept   = (state_q == StIdle) && req_i;

  // The commit edge is the one entering StResp. With LATENCY=1 that is the accept edge itself, so
  // the live inputs are used. Otherwise the copy latched at accept is used.
  assign commit = (accept && (LATENCY == 1)) || ((state_q == StWait) && (cnt_q == 4'd0));

  always_comb begin
    if (state_q == StIdle) begin
      c_we    = we_i;
      c_legal = in_legal;
      c_idx   = in_idx;
      c_wdata = wdata_i;
    end else begin
      c_we    = we_q;
      c_legal = legal_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    legal_d  = legal_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          legal_d = in_legal;
          idx_d   = in_idx;
          wdata_d = wdata_i;
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (commit) begin
      rvalid_d = 1'b1;
      err_d    = !c_legal;
      // Writes and illegal requests return zero data.
      rdata_d  = (c_legal && !c_we) ? mem_q[c_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      legal_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      legal_q  <= legal_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (commit && c_legal && c_we) begin
      mem_q[c_idx] <= c_wdata;
    end
  end

  assign ready_o  = (state_q == StIdle);
  assign stall_o  = accept || (state_q == StWait);
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Three instances with LATENCY 1, 2 and 4 share one stimulus stream.
// A timeline/array reference model predicts each accepted request's response at issue time and
// queues it. A negedge monitor compares every output of every instance on every cycle.
module tb_dmem_responder;

  localparam int unsigned Depth = 128;
  localparam int NInst = 3;

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ready_w;
  logic [2:0]  rvalid_w;
  logic [2:0]  err_w;
  logic [2:0]  stall_w;
  logic [31:0] rdata_w [NInst];

  resp_t       sb[$];
  logic [31:0] mdl_mem [NInst][Depth];
  logic [31:0] last_rdata [NInst];
  int          nf [NInst];  // earliest edge number at which each instance can accept
  int          cyc = 0;     // number of rising edges so far
  int          n_chk = 0;
  int          n_pass = 0;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (Depth),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .ready_o (ready_w[g]),
      .rvalid_o(rvalid_w[g]),
      .rdata_o (rdata_w[g]),
      .err_o   (err_w[g]),
      .stall_o (stall_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [lat%0d] edge %0d: got %h, expected %h",
                  name, lat_of(inst), cyc, act, exp);
  endtask

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < NInst; i++) begin
      nf[i] = 0;
      last_rdata[i] = 32'h0;
      for (int w = 0; w < int'(Depth); w++) mdl_mem[i][w] = 32'h0;
    end
  endtask

  // Drive one cycle of inputs and predict what each idle instance does at the coming edge.
  // Memory effects are applied at accept time: nothing else can touch memory before the commit,
  // and a reset in between clears memory anyway.
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    req = r; we = w; addr = a; wdata = d;
    if (r) begin
      for (int i = 0; i < NInst; i++) begin
        if (cyc + 1 >= nf[i]) begin
          resp_t       e;
          int unsigned word;
          logic        legal;
          word    = a >> 2;
          legal   = (a[1:0] == 2'b00) && (word < Depth);
          e.inst  = i;
          e.due   = cyc + lat_of(i);
          e.err   = !legal;
          e.rdata = 32'h0;
          if (legal) begin
            if (w) mdl_mem[i][word] = d;
            else e.rdata = mdl_mem[i][word];
          end
          sb.push_back(e);
          nf[i] = cyc + lat_of(i) + 2;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Single-cycle request followed by idle cycles with scrambled addr/wdata.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, w, a, d);
    repeat (6) drive(1'b0, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic check_inst(input int i);
    int          idx;
    logic        exp_v;
    logic        exp_e;
    logic [31:0] exp_d;
    logic        exp_rdy;
    logic        exp_stl;
    idx   = -1;
    exp_v = 1'b0;
    exp_e = 1'b0;
    for (int k = 0; k < sb.size(); k++) begin
      if (idx < 0 && sb[k].inst == i) idx = k;
    end
    if (idx >= 0 && sb[idx].due <= cyc) begin
      exp_v = 1'b1;
      exp_e = sb[idx].err;
      last_rdata[i] = sb[idx].rdata;
      sb.delete(idx);
    end
    exp_d   = last_rdata[i];
    exp_rdy = (cyc + 1 >= nf[i]);
    // Busy and not in the response cycle means the access is still waiting.
    exp_stl = exp_rdy ? req : (cyc + 2 != nf[i]);
    chk("rvalid", i, 32'(rvalid_w[i]), 32'(exp_v));
    chk("err",    i, 32'(err_w[i]),    32'(exp_e));
    chk("rdata",  i, rdata_w[i],       exp_d);
    chk("ready",  i, 32'(ready_w[i]),  32'(exp_rdy));
    chk("stall",  i, 32'(stall_w[i]),  32'(exp_stl));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NInst; i++) check_inst(i);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    model_clear();
    do_reset();

    // Reset aborts a write while the longer-latency instances are still waiting.
    drive(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    do_reset();
    issue(1'b0, 32'h10, 32'h0);

    // Write then read three cycles later.
    drive(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    issue(1'b0, 32'h20, 32'h0);
    issue(1'b0, 32'h20, 32'h0);

    // Illegal accesses, then the words they must not have touched.
    issue(1'b0, 32'h22, 32'h0);
    issue(1'b1, 32'h200, 32'hBAD0_BAD0);
    issue(1'b0, 32'h0, 32'h0);
    issue(1'b0, 32'h1FC, 32'h0);

    // Input isolation: addr/wdata scramble during WAIT.
    issue(1'b1, 32'h04, 32'h1111_1111);
    issue(1'b0, 32'h04, 32'h0);
    issue(1'b0, 32'h00, 32'h0);
    issue(1'b0, 32'h08, 32'h0);

    // Last word.
    issue(1'b1, 32'h1FC, 32'hA5A5_A5A5);
    issue(1'b0, 32'h1FC, 32'h0);

    // req held high with alternating write/read.
    for (int n = 0; n < 40; n++) begin
      drive(1'b1, 1'(n % 2 == 0), {26'h0, 4'(n % 4), 2'b00}, $urandom);
    end

    // Random traffic, biased toward a few words so read-after-write hits often.
    for (int n = 0; n < 1500; n++) begin
      int unsigned sel;
      logic [31:0] a;
      if (n == 700) do_reset();
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom | 32'h1;
      else if (sel == 1) a = {20'h0, 10'($urandom_range(128, 1000)), 2'b00};
      else if (sel == 2) a = 32'h1FC;
      else               a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom);
    end

    repeat (10) drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk("sb_drained", 0, 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
